// File: rtl/oven_pkg.sv
// oven_pkg: shared types and constants for the oven cook timer.
// State encoding, BCD digit type and the MM:SS count bundle.
package oven_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t m_t;
    bcd_t m_o;
    bcd_t s_t;
    bcd_t s_o;
  } mmss_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  function automatic bcd_t clamp_digit(
    input bcd_t d,
    input bcd_t lim
  );
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// bcd_mmss_dec: combinational one-second decrement of an MM:SS BCD count.
// Borrow ripples seconds->minutes; 00:00 saturates; nxt_zero flags a zero result.
module bcd_mmss_dec
  import oven_pkg::*;
(
  input  mmss_t cur,
  output mmss_t nxt,
  output logic  nxt_zero
);

  // Ripple-borrow decrement, seconds tens wraps to 5, ones digits wrap to 9
  always_comb begin
    nxt = cur;
    if (cur == '0) begin
      nxt = '0;
    end else if (cur.s_o != 4'd0) begin
      nxt.s_o = cur.s_o - 4'd1;
    end else begin
      nxt.s_o = DIGIT_MAX;
      if (cur.s_t != 4'd0) begin
        nxt.s_t = cur.s_t - 4'd1;
      end else begin
        nxt.s_t = SEC_TENS_MAX;
        if (cur.m_o != 4'd0) begin
          nxt.m_o = cur.m_o - 4'd1;
        end else begin
          nxt.m_o = DIGIT_MAX;
          nxt.m_t = cur.m_t - 4'd1;
        end
      end
    end
    nxt_zero = (nxt == '0);
  end

endmodule

// File: rtl/cook_timer.sv
// cook_timer: captures a BCD MM:SS cook time and counts it down at 1 Hz.
// Optional door interlock (PAUSED state, door_open port) under DOOR_INTERLOCK_EN.
module cook_timer
  import oven_pkg::*;
#(
  parameter int ALARM_SECS = 5,
  parameter int MIN_MAX    = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic       start,
  input  logic       cancel,
  input  logic [3:0] in_d0,
  input  logic [3:0] in_d1,
  input  logic [3:0] in_d2,
  input  logic [3:0] in_d3,
`ifdef DOOR_INTERLOCK_EN
  input  logic       door_open,
`endif
  output logic [3:0] cnt_d0,
  output logic [3:0] cnt_d1,
  output logic [3:0] cnt_d2,
  output logic [3:0] cnt_d3,
  output logic       heating,
  output logic       done,
  output logic [2:0] state_o
);

  localparam bcd_t       MM_T       = bcd_t'(MIN_MAX / 10);
  localparam bcd_t       MM_O       = bcd_t'(MIN_MAX % 10);
  localparam logic [6:0] MM_BIN     = 7'(MIN_MAX);
  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS - 1);

  state_t     state_q, state_d;
  mmss_t      cnt_q, cnt_d;
  logic [3:0] alarm_q, alarm_d;
  logic       heat_q, heat_d;
  logic       done_q, done_d;

  mmss_t      san;
  logic [6:0] min_bin;
  logic       san_nz;

  mmss_t      dec_nxt;
  logic       dec_zero;

  logic       door;
  logic       load_ok, start_ok, pause_ok;
  logic       run_tick, alarm_tick;
  logic       sel_cancel, sel_load, sel_start;
  logic       sel_pause, sel_run, sel_alarm;

`ifdef DOOR_INTERLOCK_EN
  assign door = door_open;
`else
  assign door = 1'b0;
`endif

  bcd_mmss_dec u_dec (
    .cur      (cnt_q),
    .nxt      (dec_nxt),
    .nxt_zero (dec_zero)
  );

  // Clamp entered digits to a legal MM:SS and cap minutes at MIN_MAX
  always_comb begin
    san.s_o = clamp_digit(in_d0, DIGIT_MAX);
    san.s_t = clamp_digit(in_d1, SEC_TENS_MAX);
    san.m_o = clamp_digit(in_d2, DIGIT_MAX);
    san.m_t = clamp_digit(in_d3, DIGIT_MAX);
    min_bin = 7'(san.m_t) * 7'd10 + 7'(san.m_o);
    if (min_bin > MM_BIN) begin
      san.m_t = MM_T;
      san.m_o = MM_O;
    end
    san_nz = (san != '0);
  end

  // Qualify each request, then resolve cancel > load > start > door > tick
  always_comb begin
    load_ok    = load & san_nz &
                 (state_q inside {ST_IDLE, ST_LOADED, ST_DONE});
    start_ok   = start & ~door &
                 (state_q inside {ST_LOADED, ST_PAUSED});
`ifdef DOOR_INTERLOCK_EN
    pause_ok   = door & (state_q == ST_RUNNING);
`else
    pause_ok   = 1'b0;
`endif
    run_tick   = tick_1hz & (state_q == ST_RUNNING);
    alarm_tick = tick_1hz & (state_q == ST_DONE);

    sel_cancel = cancel;
    sel_load   = ~cancel & load_ok;
    sel_start  = ~cancel & ~load_ok & start_ok;
    sel_pause  = ~cancel & pause_ok;
    sel_run    = ~cancel & ~pause_ok & run_tick;
    sel_alarm  = ~cancel & ~load_ok & alarm_tick;
  end

  // Next-state, next-count and registered output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    unique case (1'b1)
      sel_cancel: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        alarm_d = '0;
      end
      sel_load: begin
        state_d = ST_LOADED;
        cnt_d   = san;
        alarm_d = '0;
      end
      sel_start: begin
        state_d = ST_RUNNING;
      end
      sel_pause: begin
        state_d = ST_PAUSED;
      end
      sel_run: begin
        cnt_d = dec_nxt;
        if (dec_zero) begin
          state_d = ST_DONE;
          alarm_d = '0;
        end
      end
      sel_alarm: begin
        if (alarm_q == ALARM_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          alarm_d = '0;
        end else begin
          alarm_d = alarm_q + 4'd1;
        end
      end
      default: begin
      end
    endcase
    heat_d = (state_d == ST_RUNNING);
    done_d = (state_d == ST_DONE);
  end

  // State, count, alarm counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      alarm_q <= '0;
      heat_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      heat_q  <= heat_d;
      done_q  <= done_d;
    end
  end

  assign cnt_d0  = cnt_q.s_o;
  assign cnt_d1  = cnt_q.s_t;
  assign cnt_d2  = cnt_q.m_o;
  assign cnt_d3  = cnt_q.m_t;
  assign heating = heat_q & ~door;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer: directed vector table plus hand sequences for cook_timer.
// Door interlock sequence compiles in when DOOR_INTERLOCK_EN is defined.
module tb_cook_timer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_PAUS = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] in_d0 = '0, in_d1 = '0, in_d2 = '0, in_d3 = '0;
  logic       door_open = 1'b0;
  logic [3:0] cnt_d0, cnt_d1, cnt_d2, cnt_d3;
  logic       heating, done;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cook_timer dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .load     (load),
    .start    (start),
    .cancel   (cancel),
    .in_d0    (in_d0),
    .in_d1    (in_d1),
    .in_d2    (in_d2),
    .in_d3    (in_d3),
`ifdef DOOR_INTERLOCK_EN
    .door_open(door_open),
`endif
    .cnt_d0   (cnt_d0),
    .cnt_d1   (cnt_d1),
    .cnt_d2   (cnt_d2),
    .cnt_d3   (cnt_d3),
    .heating  (heating),
    .done     (done),
    .state_o  (state_o)
  );

  typedef struct {
    logic        l, s, c, t;
    logic [15:0] din;
    logic [15:0] cnt;
    logic [2:0]  st;
    logic        heat, dn;
  } vec_t;

  vec_t v[17];

  function automatic logic [15:0] cnt_now();
    return {cnt_d3, cnt_d2, cnt_d1, cnt_d0};
  endfunction

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx,
                         input logic [15:0] c, input logic [2:0] st,
                         input logic h, input logic d);
    chk(nm, idx, {11'd0, cnt_now(), state_o, heating, done},
        {11'd0, c, st, h, d});
  endtask

  task automatic step(input logic l, input logic s, input logic c,
                      input logic t, input logic [15:0] din);
    load = l;
    start = s;
    cancel = c;
    tick_1hz = t;
    {in_d3, in_d2, in_d1, in_d0} = din;
    @(posedge clk);
    #1;
    load = 1'b0;
    start = 1'b0;
    cancel = 1'b0;
    tick_1hz = 1'b0;
  endtask

  initial begin
    v[0]  = '{0,0,0,0, 16'h0000, 16'h0000, S_IDLE, 0, 0};
    v[1]  = '{1,0,0,0, 16'h0000, 16'h0000, S_IDLE, 0, 0};
    v[2]  = '{1,0,0,0, 16'h007C, 16'h0059, S_LOAD, 0, 0};
    v[3]  = '{1,0,0,0, 16'hCC34, 16'h9934, S_LOAD, 0, 0};
    v[4]  = '{0,1,0,1, 16'h0000, 16'h9934, S_RUN,  1, 0};
    v[5]  = '{0,0,0,1, 16'h0000, 16'h9933, S_RUN,  1, 0};
    v[6]  = '{1,0,0,0, 16'h0011, 16'h9933, S_RUN,  1, 0};
    v[7]  = '{0,1,0,1, 16'h0000, 16'h9932, S_RUN,  1, 0};
    v[8]  = '{0,0,1,1, 16'h0000, 16'h0000, S_IDLE, 0, 0};
    v[9]  = '{1,0,0,0, 16'h0100, 16'h0100, S_LOAD, 0, 0};
    v[10] = '{0,1,0,0, 16'h0000, 16'h0100, S_RUN,  1, 0};
    v[11] = '{0,0,0,1, 16'h0000, 16'h0059, S_RUN,  1, 0};
    v[12] = '{0,0,1,0, 16'h0000, 16'h0000, S_IDLE, 0, 0};
    v[13] = '{1,0,0,0, 16'h1000, 16'h1000, S_LOAD, 0, 0};
    v[14] = '{0,1,0,0, 16'h0000, 16'h1000, S_RUN,  1, 0};
    v[15] = '{0,0,0,1, 16'h0000, 16'h0959, S_RUN,  1, 0};
    v[16] = '{1,0,1,0, 16'h0042, 16'h0000, S_IDLE, 0, 0};

    #2;
    chk_all("reset_async", 0, 16'h0000, S_IDLE, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("reset_held", 0, 16'h0000, S_IDLE, 0, 0);

    for (int i = 0; i < 17; i++) begin
      step(v[i].l, v[i].s, v[i].c, v[i].t, v[i].din);
      chk_all("vec", i, v[i].cnt, v[i].st, v[i].heat, v[i].dn);
    end

    // 01:30 full countdown to DONE
    step(1, 0, 0, 0, 16'h0130);
    chk_all("cd_load", 0, 16'h0130, S_LOAD, 0, 0);
    step(0, 1, 0, 0, 16'h0000);
    chk_all("cd_start", 0, 16'h0130, S_RUN, 1, 0);
    for (int i = 1; i <= 90; i++) begin
      step(0, 0, 0, 1, 16'h0000);
      if (i < 90)
        chk_all("cd_tick", i, to_bcd(90 - i), S_RUN, 1, 0);
      else
        chk_all("cd_tick", i, 16'h0000, S_DONE, 0, 1);
      if (i == 30) begin
        step(0, 0, 0, 0, 16'h0000);
        chk_all("cd_hold", i, to_bcd(60), S_RUN, 1, 0);
      end
    end

    // Alarm window then auto-return
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 1, 16'h0000);
      if (i < 5)
        chk_all("alarm", i, 16'h0000, S_DONE, 0, 1);
      else
        chk_all("alarm", i, 16'h0000, S_IDLE, 0, 0);
    end

    // Reload from DONE mid-alarm, then full alarm again
    step(1, 0, 0, 0, 16'h0002);
    step(0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    chk_all("dl_done", 0, 16'h0000, S_DONE, 0, 1);
    step(0, 0, 0, 1, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    step(1, 0, 0, 1, 16'h0000);
    chk_all("dl_zero_load", 0, 16'h0000, S_DONE, 0, 1);
    step(1, 0, 0, 1, 16'h0005);
    chk_all("dl_reload", 0, 16'h0005, S_LOAD, 0, 0);
    step(0, 1, 0, 0, 16'h0000);
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 1, 16'h0000);
    chk_all("dl_done2", 0, 16'h0000, S_DONE, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 1, 16'h0000);
      if (i < 5)
        chk_all("dl_alarm", i, 16'h0000, S_DONE, 0, 1);
      else
        chk_all("dl_alarm", i, 16'h0000, S_IDLE, 0, 0);
    end

    // Asynchronous reset mid-count
    step(1, 0, 0, 0, 16'h0046);
    step(0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    chk_all("rst_pre", 0, 16'h0045, S_RUN, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 0, 16'h0000, S_IDLE, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 1, 0, 1, 16'h0000);
    chk_all("rst_after", 0, 16'h0000, S_IDLE, 0, 0);

`ifdef DOOR_INTERLOCK_EN
    step(1, 0, 0, 0, 16'h0021);
    step(0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 16'h0000);
    chk_all("door_pre", 0, 16'h0020, S_RUN, 1, 0);
    door_open = 1'b1;
    #1;
    chk("door_heat_mask", 0, {31'd0, heating}, 32'd0);
    step(0, 0, 0, 1, 16'h0000);
    chk_all("door_pause", 0, 16'h0020, S_PAUS, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1, 16'h0000);
      chk_all("door_hold", i, 16'h0020, S_PAUS, 0, 0);
    end
    step(0, 1, 0, 0, 16'h0000);
    chk_all("door_start_open", 0, 16'h0020, S_PAUS, 0, 0);
    door_open = 1'b0;
    step(0, 0, 0, 0, 16'h0000);
    step(0, 1, 0, 0, 16'h0000);
    chk_all("door_resume", 0, 16'h0020, S_RUN, 1, 0);
    step(0, 0, 0, 1, 16'h0000);
    chk_all("door_tick", 0, 16'h0019, S_RUN, 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
